// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the LED shift sequencer: default width, FSM state
// encodings and shift-direction constants.
package shift_sequencer_pkg;

    // Default width of the shifted LED pattern
    localparam int DEF_NUM_W = 8;

    // Sequencer run state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift direction encodings as seen on the dir output
    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_if.sv
// Control/status bundle between the debounced key/switch front end and the
// shift sequencer. The master side issues pulses and settings, the slave side
// (the sequencer) reports run status and drives the LED pattern.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int NUM_W = DEF_NUM_W
);
    logic             start_pls;
    logic             dir_pls;
    logic             load_pls;
    logic [NUM_W-1:0] load_val;
    logic [1:0]       speed;
    logic             rotate;
    logic             fill_bit;
    logic             bounce;
    logic             busy;
    logic             dir;
    logic             shift_stb;
    logic [NUM_W-1:0] ledr;

    modport master (
        output start_pls, dir_pls, load_pls, load_val, speed, rotate, fill_bit, bounce,
        input  busy, dir, shift_stb, ledr
    );

    modport slave (
        input  start_pls, dir_pls, load_pls, load_val, speed, rotate, fill_bit, bounce,
        output busy, dir, shift_stb, ledr
    );

endinterface : shift_sequencer_if

// File: rtl/shift_sequencer_core.sv
// Datapath for the LED shift register. Load takes precedence over shift;
// the caller is responsible for choosing the inserted bit.
module shift_reg_core #(
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [NUM_W-1:0] load_val,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             in_bit,
    output logic [NUM_W-1:0] value
);

    logic [NUM_W-1:0] value_r;

    // Pattern register: reset clears, load overwrites, shift moves one place
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {NUM_W{1'b0}};
        end else if (load_en) begin
            value_r <= load_val;
        end else if (shift_en) begin
            if (dir) begin
                value_r <= {value_r[NUM_W-2:0], in_bit};
            end else begin
                value_r <= {in_bit, value_r[NUM_W-1:1]};
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule : shift_reg_core

// File: rtl/shift_sequencer.sv
// Timed LED shift sequencer. A tick counter paces shifts at a rate selected
// by speed; a position counter tracks how far the pattern has travelled so
// that bounce mode can reverse direction at the far end.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int NUM_W       = DEF_NUM_W,
    parameter int BASE_PERIOD = 3125000,
    parameter int TICK_W      = 26
) (
    input  logic              clk,
    input  logic              key0_rst,
    shift_sequencer_if.slave  bus
);

    localparam int                POS_W    = (NUM_W > 2) ? $clog2(NUM_W) : 1;
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(NUM_W - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic              rst_s;
    state_t            state_r;
    state_t            state_n_s;
    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_n_s;
    logic [TICK_W-1:0] period_r;
    logic [TICK_W-1:0] period_cur_s;
    logic [POS_W-1:0]  pos_r;
    logic [POS_W-1:0]  pos_n_s;
    logic              dir_r;
    logic              dir_n_s;
    logic              busy_r;
    logic              shift_stb_r;
    logic              due_s;
    logic              shift_en_s;
    logic              in_bit_s;
    logic [NUM_W-1:0]  value_s;

    assign rst_s = ~key0_rst;

    // Period is re-evaluated only at the start of a tick period so that a
    // speed change mid-period waits for the next period
    always_comb begin
        period_cur_s = period_r;
        if (tick_r == TICK_ZERO) begin
            period_cur_s = TICK_W'(BASE_PERIOD) << bus.speed;
        end else begin
            period_cur_s = period_r;
        end
    end

    // A shift falls due on the last tick of the period while running
    always_comb begin
        due_s = 1'b0;
        if (state_r == ST_RUN) begin
            due_s = (tick_r == (period_cur_s - TICK_ONE));
        end else begin
            due_s = 1'b0;
        end
    end

    // Inserted bit: recirculate the outgoing bit when rotating, else fill
    always_comb begin
        in_bit_s = bus.fill_bit;
        if (bus.rotate) begin
            if (dir_r == DIR_L) begin
                in_bit_s = value_s[NUM_W-1];
            end else begin
                in_bit_s = value_s[0];
            end
        end else begin
            in_bit_s = bus.fill_bit;
        end
    end

    // Next-state logic with priority load > start > dir > timed shift
    always_comb begin
        state_n_s  = state_r;
        pos_n_s    = pos_r;
        dir_n_s    = dir_r;
        shift_en_s = 1'b0;
        if (state_r == ST_RUN) begin
            tick_n_s = tick_r + TICK_ONE;
        end else begin
            tick_n_s = TICK_ZERO;
        end

        if (bus.load_pls || bus.start_pls) begin
            tick_n_s = TICK_ZERO;
            pos_n_s  = {POS_W{1'b0}};
            if (bus.start_pls) begin
                case (state_r)
                    ST_IDLE: state_n_s = ST_RUN;
                    ST_RUN:  state_n_s = ST_IDLE;
                    default: state_n_s = ST_IDLE;
                endcase
            end else begin
                state_n_s = state_r;
            end
        end else if (bus.dir_pls) begin
            dir_n_s  = ~dir_r;
            pos_n_s  = {POS_W{1'b0}};
            tick_n_s = TICK_ZERO;
        end else if (due_s) begin
            shift_en_s = 1'b1;
            tick_n_s   = TICK_ZERO;
            if (bus.bounce && (pos_r == (POS_LAST - POS_W'(1)))) begin
                dir_n_s = ~dir_r;
                pos_n_s = {POS_W{1'b0}};
            end else if (pos_r >= POS_LAST) begin
                pos_n_s = {POS_W{1'b0}};
            end else begin
                pos_n_s = pos_r + POS_W'(1);
            end
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // Control registers, all cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r     <= ST_IDLE;
            tick_r      <= TICK_ZERO;
            period_r    <= TICK_W'(BASE_PERIOD);
            pos_r       <= {POS_W{1'b0}};
            dir_r       <= DIR_R;
            busy_r      <= 1'b0;
            shift_stb_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            tick_r      <= tick_n_s;
            period_r    <= period_cur_s;
            pos_r       <= pos_n_s;
            dir_r       <= dir_n_s;
            busy_r      <= (state_n_s == ST_RUN);
            shift_stb_r <= shift_en_s;
        end
    end

    shift_reg_core #(
        .NUM_W (NUM_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst_s),
        .load_en  (bus.load_pls),
        .load_val (bus.load_val),
        .shift_en (shift_en_s),
        .dir      (dir_r),
        .in_bit   (in_bit_s),
        .value    (value_s)
    );

    assign bus.busy      = busy_r;
    assign bus.dir       = dir_r;
    assign bus.shift_stb = shift_stb_r;
    assign bus.ledr      = value_s;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with BASE_PERIOD=4.
module tb_shift_sequencer;

    logic clk;
    logic key0_rst;
    int   n_checks;
    int   n_fail;

    shift_sequencer_if #(.NUM_W(8)) bus ();

    shift_sequencer #(
        .NUM_W       (8),
        .BASE_PERIOD (4),
        .TICK_W      (26)
    ) dut (
        .clk      (clk),
        .key0_rst (key0_rst),
        .bus      (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never completes
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load_val = v;
        bus.load_pls = 1'b1;
        cyc(1);
        bus.load_pls = 1'b0;
    endtask

    task automatic do_start();
        bus.start_pls = 1'b1;
        cyc(1);
        bus.start_pls = 1'b0;
    endtask

    task automatic do_dir();
        bus.dir_pls = 1'b1;
        cyc(1);
        bus.dir_pls = 1'b0;
    endtask

    task automatic test_reset();
        key0_rst = 1'b0;
        cyc(2);
        n_checks++; if (bus.ledr !== 8'h00) begin n_fail++; $display("FAIL reset_ledr got %h want 00", bus.ledr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", bus.dir); end
        n_checks++; if (bus.shift_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b want 0", bus.shift_stb); end
        key0_rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_rotate_right();
        logic [7:0] exp_seq [3];
        logic [7:0] prev;
        exp_seq[0] = 8'hC0; exp_seq[1] = 8'h60; exp_seq[2] = 8'h30;
        bus.rotate = 1'b1;
        bus.speed  = 2'd0;
        do_load(8'h81);
        n_checks++; if (bus.ledr !== 8'h81) begin n_fail++; $display("FAIL rr_load got %h want 81", bus.ledr); end
        do_start();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy got %b want 1", bus.busy); end
        prev = 8'h81;
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            n_checks++; if (bus.ledr !== prev) begin n_fail++; $display("FAIL rr_hold%0d got %h want %h", k, bus.ledr, prev); end
            n_checks++; if (bus.shift_stb !== 1'b0) begin n_fail++; $display("FAIL rr_stb_lo%0d got %b want 0", k, bus.shift_stb); end
            cyc(1);
            n_checks++; if (bus.ledr !== exp_seq[k]) begin n_fail++; $display("FAIL rr_shift%0d got %h want %h", k, bus.ledr, exp_seq[k]); end
            n_checks++; if (bus.shift_stb !== 1'b1) begin n_fail++; $display("FAIL rr_stb_hi%0d got %b want 1", k, bus.shift_stb); end
            prev = exp_seq[k];
        end
        do_start();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_stop got %b want 0", bus.busy); end
        cyc(8);
        n_checks++; if (bus.ledr !== 8'h30) begin n_fail++; $display("FAIL rr_idle_hold got %h want 30", bus.ledr); end
    endtask

    task automatic test_bounce_left();
        logic [7:0] exp_v;
        logic       exp_d;
        bus.rotate   = 1'b0;
        bus.fill_bit = 1'b0;
        bus.bounce   = 1'b1;
        do_load(8'h01);
        do_dir();
        n_checks++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL bl_dir got %b want 1", bus.dir); end
        do_start();
        exp_v = 8'h01;
        for (int s = 1; s <= 7; s++) begin
            cyc(4);
            exp_v = exp_v << 1;
            exp_d = (s == 7) ? 1'b0 : 1'b1;
            n_checks++; if (bus.ledr !== exp_v) begin n_fail++; $display("FAIL bl_step%0d got %h want %h", s, bus.ledr, exp_v); end
            n_checks++; if (bus.dir !== exp_d) begin n_fail++; $display("FAIL bl_dir%0d got %b want %b", s, bus.dir, exp_d); end
        end
        cyc(4);
        n_checks++; if (bus.ledr !== 8'h40) begin n_fail++; $display("FAIL bl_back got %h want 40", bus.ledr); end
        do_start();
        bus.bounce = 1'b0;
    endtask

    task automatic test_stop_restart();
        int hold_bad;
        do_load(8'h80);
        do_start();
        cyc(8);
        n_checks++; if (bus.ledr !== 8'h20) begin n_fail++; $display("FAIL sr_two got %h want 20", bus.ledr); end
        do_start();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sr_busy got %b want 0", bus.busy); end
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.ledr !== 8'h20) hold_bad++;
        end
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL sr_hold got %0d changed cycles want 0", hold_bad); end
        do_start();
        cyc(3);
        n_checks++; if (bus.ledr !== 8'h20) begin n_fail++; $display("FAIL sr_early got %h want 20", bus.ledr); end
        cyc(1);
        n_checks++; if (bus.ledr !== 8'h10) begin n_fail++; $display("FAIL sr_resume got %h want 10", bus.ledr); end
        do_start();
    endtask

    task automatic test_same_cycle();
        bus.load_val  = 8'h0F;
        bus.load_pls  = 1'b1;
        bus.start_pls = 1'b1;
        cyc(1);
        bus.load_pls  = 1'b0;
        bus.start_pls = 1'b0;
        n_checks++; if (bus.ledr !== 8'h0F) begin n_fail++; $display("FAIL sc_load got %h want 0f", bus.ledr); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sc_busy got %b want 1", bus.busy); end
        cyc(3);
        do_dir();
        n_checks++; if (bus.ledr !== 8'h0F) begin n_fail++; $display("FAIL sc_drop got %h want 0f", bus.ledr); end
        n_checks++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL sc_dir got %b want 1", bus.dir); end
        n_checks++; if (bus.shift_stb !== 1'b0) begin n_fail++; $display("FAIL sc_stb got %b want 0", bus.shift_stb); end
        cyc(3);
        n_checks++; if (bus.ledr !== 8'h0F) begin n_fail++; $display("FAIL sc_wait got %h want 0f", bus.ledr); end
        cyc(1);
        n_checks++; if (bus.ledr !== 8'h1E) begin n_fail++; $display("FAIL sc_next got %h want 1e", bus.ledr); end
        do_start();
    endtask

    task automatic test_speed_reset();
        bus.rotate = 1'b1;
        bus.speed  = 2'd2;
        do_load(8'h01);
        do_start();
        cyc(15);
        n_checks++; if (bus.ledr !== 8'h01) begin n_fail++; $display("FAIL sp_hold got %h want 01", bus.ledr); end
        cyc(1);
        n_checks++; if (bus.ledr !== 8'h02) begin n_fail++; $display("FAIL sp_first got %h want 02", bus.ledr); end
        n_checks++; if (bus.shift_stb !== 1'b1) begin n_fail++; $display("FAIL sp_stb got %b want 1", bus.shift_stb); end
        cyc(16);
        n_checks++; if (bus.ledr !== 8'h04) begin n_fail++; $display("FAIL sp_second got %h want 04", bus.ledr); end
        cyc(5);
        key0_rst = 1'b0;
        cyc(1);
        n_checks++; if (bus.ledr !== 8'h00) begin n_fail++; $display("FAIL rr_abort_ledr got %h want 00", bus.ledr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_abort_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL rr_abort_dir got %b want 0", bus.dir); end
        key0_rst  = 1'b1;
        bus.speed = 2'd0;
        cyc(8);
        n_checks++; if (bus.ledr !== 8'h00) begin n_fail++; $display("FAIL rr_after got %h want 00", bus.ledr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_after_busy got %b want 0", bus.busy); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        key0_rst      = 1'b0;
        bus.start_pls = 1'b0;
        bus.dir_pls   = 1'b0;
        bus.load_pls  = 1'b0;
        bus.load_val  = 8'h00;
        bus.speed     = 2'd0;
        bus.rotate    = 1'b0;
        bus.fill_bit  = 1'b0;
        bus.bounce    = 1'b0;
        test_reset();
        test_rotate_right();
        test_bounce_left();
        test_stop_restart();
        test_same_cycle();
        test_speed_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Autonomous controller for the board's 8-bit LED shift register.
- Replaces per-press manual shifting with a timed sequence: shifts at a programmable rate, in either direction, optionally rotating, optionally ping-ponging end to end.
- Sits between the debounced key/switch pulses and the LED bus.
- Owns the shift register through one datapath sub-module and drives its shift strobes.

Parameters:
- NUM_W, 8, width of the shifted pattern and of `ledr`.
- BASE_PERIOD, 3125000, clock cycles per shift at `speed`=0 (62.5 ms at 50 MHz); must be >= 2.
- TICK_W, 26, width of the tick counter; must hold BASE_PERIOD<<3.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- key0_rst  in  1  synchronous active-low reset; the block uses rst = ~key0_rst internally.
- start_pls  in  1  one-cycle pulse (debounced key); toggles run/stop.
- dir_pls  in  1  one-cycle pulse; reverses the shift direction.
- load_pls  in  1  one-cycle pulse; loads `load_val` into the register.
- load_val  in  NUM_W  pattern to load.
- speed  in  2  period select; period = BASE_PERIOD << speed.
- rotate  in  1  1 = shifted-in bit is the bit shifted out; 0 = shifted-in bit is `fill_bit`.
- fill_bit  in  1  bit inserted when `rotate`=0.
- bounce  in  1  level; when 1, direction auto-reverses at the ends.
- busy  out  1  1 while in RUN.
- dir  out  1  0 = right, 1 = left.
- shift_stb  out  1  registered one-cycle pulse, high the cycle after each timed shift.
- ledr  out  NUM_W  current register contents.

Behaviour:
- Reset (key0_rst low at an edge), all state cleared:
  - ledr=0, busy=0, dir=0, shift_stb=0.
  - Tick counter=0, position counter=0, state=IDLE.
  - Reset mid-run aborts the sequence immediately.
- FSM states:
  - IDLE: stopped.
  - RUN: tick counter increments each cycle.
- Transitions:
  - start_pls in IDLE: to RUN, counter cleared to 0.
  - start_pls in RUN: to IDLE, counter cleared to 0, ledr frozen.
- Timing:
  - Shift occurs at the edge where counter == period-1; the counter then returns to 0.
  - First shift changes ledr exactly `period` edges after the start edge; subsequent shifts are every `period` cycles.
- `speed` is sampled only when the counter is 0. A change mid-period takes effect from the next period.
- Shift arithmetic (width NUM_W, no growth):
  - Right: ledr>>1 with in-bit at [NUM_W-1].
  - Left: ledr<<1 with in-bit at [0].
  - In-bit = rotate ? outgoing bit (right: ledr[0], left: ledr[NUM_W-1]) : fill_bit.
- Position counter 0..NUM_W-1:
  - Increments on each timed shift.
  - Cleared on load, on start, and on any direction change.
  - When bounce=1 and a timed shift brings the counter to NUM_W-1: dir toggles and the counter clears in that same edge, so the next shift goes the other way.
  - When bounce=0 the counter wraps silently and dir is unchanged.
- Same-cycle priority: reset > load_pls > start_pls > dir_pls > timed shift.
  - load_pls: updates ledr, clears counters, does not change state. A shift due that cycle is dropped. start_pls in the same cycle is still honoured.
  - dir_pls coincident with a due shift: the direction toggles and that shift is dropped (counter restarts).
  - dir_pls is honoured in IDLE too; it only changes `dir`.
- In IDLE no shift ever occurs; ledr changes only via load or reset.

Decomposition:
- Shared package/header:
  - NUM_W default.
  - FSM state encodings (ST_IDLE, ST_RUN).
  - Direction constants DIR_R=0, DIR_L=1.
- Sub-module shift_reg_core:
  - Holds the NUM_W register.
  - Inputs: rst, load_en, load_val, shift_en, dir, in_bit.
  - Output: value.
- shift_sequencer keeps the FSM, tick/position counters, in-bit mux and priority logic.

Test Plan (BASE_PERIOD=4):
1. Reset behaviour: hold key0_rst low 2 cycles -> ledr=0x00, busy=0, dir=0, shift_stb=0.
2. Timed rotate right: load_val=0x81 + load_pls, rotate=1, speed=0, then start_pls -> ledr=0xC0 at 4 edges after start, then 0x60, 0x30, every 4 cycles; shift_stb pulses once per shift; busy=1.
3. Bounce left: load 0x01, dir_pls (dir=1), bounce=1, rotate=0, fill_bit=0, start -> ledr steps 0x02…0x80 over 7 shifts, dir flips to 0 at the 7th, next shift gives 0x40.
4. Stop and restart: start_pls after 2 shifts -> busy=0 and ledr holds for 20 cycles; start_pls again -> next shift exactly 4 cycles later.
5. Same-cycle events:
   - load_pls with start_pls in IDLE, load_val=0x0F -> ledr=0x0F and busy=1 next edge.
   - dir_pls on a shift-due cycle -> no shift that cycle, dir toggled.
6. Speed and reset: speed=2 -> shifts every 16 cycles; key0_rst low during RUN -> ledr=0, busy=0 at the next edge.
